// File: rtl/mas_prog_sequencer_if.sv
// Host byte stream and core programming pins of the MAS program sequencer.
// The master side is the host/test harness, the slave side is the sequencer.
interface mas_prog_sequencer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        pr;
  logic        cpu_en;
  logic [15:0] instr_out;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, pr, cpu_en, instr_out
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, pr, cpu_en, instr_out
  );
endinterface

// File: rtl/mas_prog_sequencer.sv
// Program-load and run sequencer for the MAS core: buffers a host byte stream
// as 16-bit words, bursts them in programming mode, then runs the core for a budget.
module mas_prog_sequencer #(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned RUN_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rstz,
  input  logic                 start,
  input  logic [ADDR_W:0]      prog_len,
  input  logic [RUN_CNT_W-1:0] run_cycles,
  input  logic                 abort,
  mas_prog_sequencer_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W:0]      word_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_PRIME, S_BURST, S_RUN} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [RUN_CNT_W-1:0] rc_q, rc_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [7:0]           hi_q, hi_d;
  logic                 lo_phase_q, lo_phase_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic                 byte_ready_q, byte_ready_d;
  logic                 pr_q, pr_d;
  logic                 cpu_en_q, cpu_en_d;
  logic [15:0]          instr_q, instr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [15:0]          mem_q [IMEM_DEPTH];
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [15:0]          mem_wdata;
  logic                 xfer;

  // Next state; PRIME uses idx as a phase bit so pr rises one cycle after the last byte.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rc_d       = rc_q;
    run_cnt_d  = run_cnt_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    lo_phase_d = lo_phase_q;
    word_cnt_d = word_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = word_cnt_q[ADDR_W-1:0];
    mem_wdata  = {hi_q, bus.byte_in};
    xfer       = bus.byte_valid && byte_ready_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (prog_len != '0 && prog_len <= CNT_W'(IMEM_DEPTH)) begin
            len_d      = prog_len;
            rc_d       = run_cycles;
            done_d     = 1'b0;
            err_d      = 1'b0;
            word_cnt_d = '0;
            lo_phase_d = 1'b0;
            state_d    = S_RECV;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b0;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          if (!lo_phase_q) begin
            hi_d       = bus.byte_in;
            lo_phase_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            word_cnt_d = word_cnt_q + CNT_W'(1);
            lo_phase_d = 1'b0;
            if (word_cnt_q + CNT_W'(1) == len_q) begin
              state_d = S_PRIME;
              idx_d   = '0;
            end
          end
        end
      end
      S_PRIME: begin
        if (idx_q == '0) begin
          idx_d = CNT_W'(1);
        end else begin
          idx_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (idx_q == len_q - CNT_W'(1)) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (rc_q != '0 && run_cnt_q == rc_q - RUN_CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      done_d  = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    byte_ready_d = (state_d == S_RECV);
    pr_d         = (state_d == S_PRIME && idx_d != '0) || (state_d == S_BURST);
    cpu_en_d     = pr_d || (state_d == S_RUN);
    instr_d      = (state_d == S_BURST) ? mem_q[idx_d[ADDR_W-1:0]] : 16'h0000;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      rc_q         <= '0;
      run_cnt_q    <= '0;
      idx_q        <= '0;
      hi_q         <= '0;
      lo_phase_q   <= 1'b0;
      word_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      pr_q         <= 1'b0;
      cpu_en_q     <= 1'b0;
      instr_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rc_q         <= rc_d;
      run_cnt_q    <= run_cnt_d;
      idx_q        <= idx_d;
      hi_q         <= hi_d;
      lo_phase_q   <= lo_phase_d;
      word_cnt_q   <= word_cnt_d;
      byte_ready_q <= byte_ready_d;
      pr_q         <= pr_d;
      cpu_en_q     <= cpu_en_d;
      instr_q      <= instr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Program buffer holds no reset: contents are only read after being written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.pr         = pr_q;
  assign bus.cpu_en     = cpu_en_q;
  assign bus.instr_out  = instr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign word_cnt       = word_cnt_q;

endmodule

// File: tb/tb_mas_prog_sequencer.sv
// Directed + randomized bench for mas_prog_sequencer; expected traces are built
// from the program list, length and run budget of each load.
module tb_mas_prog_sequencer;
  logic        clk;
  logic        rstz;
  logic        start;
  logic        abort;
  logic [4:0]  prog_len;
  logic [15:0] run_cycles;
  logic        busy, done, err;
  logic [4:0]  word_cnt;

  mas_prog_sequencer_if bus ();

  mas_prog_sequencer dut (
    .clk        (clk),
    .rstz       (rstz),
    .start      (start),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int exp_len  = 0;
  logic [15:0] prog [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] prog_byte(input int j);
    logic [15:0] w;
    w = prog[4'(j / 2)];
    return (j % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic start_load(input int len, input int rc, input bit with_abort);
    exp_len    = len;
    prog_len   = 5'(len);
    run_cycles = 16'(rc);
    start      = 1'b1;
    abort      = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(bus.byte_ready), 1);
    chk("start_err", 32'(err), 0);
    chk("start_done", 32'(done), 0);
    chk("start_wcnt", 32'(word_cnt), 0);
  endtask

  // Sends the first n program bytes with fixed or random stall gaps before each.
  task automatic send_bytes(input int n, input int gap, input bit rnd);
    int g;
    for (int j = 0; j < n; j++) begin
      g = rnd ? int'($urandom_range(3, 0)) : gap;
      for (int k = 0; k < g; k++) begin
        bus.byte_valid = 1'b0;
        tick();
        chk("stall_ready", 32'(bus.byte_ready), 1);
        chk("stall_wcnt", 32'(word_cnt), j / 2);
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = prog_byte(j);
      tick();
      bus.byte_valid = 1'b0;
      chk("byte_wcnt", 32'(word_cnt), (j + 1) / 2);
      if (j % 2 == 1 && (j + 1) / 2 == exp_len)
        chk("last_ready", 32'(bus.byte_ready), 0);
      else
        chk("byte_ready", 32'(bus.byte_ready), 1);
    end
  endtask

  task automatic check_prime_burst(input int len);
    chk("bubble_pr", 32'(bus.pr), 0);
    chk("bubble_en", 32'(bus.cpu_en), 0);
    chk("bubble_busy", 32'(busy), 1);
    chk("bubble_wcnt", 32'(word_cnt), len);
    tick();
    chk("prime_pr", 32'(bus.pr), 1);
    chk("prime_en", 32'(bus.cpu_en), 1);
    chk("prime_instr", 32'(bus.instr_out), 0);
    for (int i = 0; i < len; i++) begin
      tick();
      chk("burst_pr", 32'(bus.pr), 1);
      chk("burst_en", 32'(bus.cpu_en), 1);
      chk("burst_instr", 32'(bus.instr_out), 32'(prog[4'(i)]));
    end
  endtask

  task automatic check_run(input int len, input int rc);
    check_prime_burst(len);
    for (int c = 0; c < rc; c++) begin
      tick();
      chk("run_pr", 32'(bus.pr), 0);
      chk("run_en", 32'(bus.cpu_en), 1);
      chk("run_instr", 32'(bus.instr_out), 0);
      chk("run_done", 32'(done), 0);
    end
    tick();
    chk("end_en", 32'(bus.cpu_en), 0);
    chk("end_pr", 32'(bus.pr), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_done", 32'(done), 1);
    chk("end_err", 32'(err), 0);
    chk("end_ready", 32'(bus.byte_ready), 0);
    chk("end_wcnt", 32'(word_cnt), len);
  endtask

  task automatic set_test1_prog();
    prog[0] = 16'h0003;
    prog[1] = 16'h0502;
    prog[2] = 16'h1500;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pr"}, 32'(bus.pr), 0);
    chk({tag, "_en"}, 32'(bus.cpu_en), 0);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
    chk({tag, "_instr"}, 32'(bus.instr_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_wcnt"}, 32'(word_cnt), 0);
  endtask

  initial begin
    int len, rc;
    rstz           = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    prog_len       = '0;
    run_cycles     = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rstz = 1'b1;
    tick();

    // Load and run, back-to-back bytes
    set_test1_prog();
    start_load(3, 5, 1'b0);
    send_bytes(6, 0, 1'b0);
    check_run(3, 5);

    // Same program with 3 stall cycles before every byte; start while busy is ignored
    start_load(3, 5, 1'b0);
    start    = 1'b1;
    prog_len = 5'd0;
    tick();
    start = 1'b0;
    chk("busy_start_err", 32'(err), 0);
    chk("busy_start_ready", 32'(bus.byte_ready), 1);
    send_bytes(6, 3, 1'b0);
    check_run(3, 5);

    // Illegal lengths
    for (int t = 0; t < 2; t++) begin
      prog_len = (t == 0) ? 5'd0 : 5'd17;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("illegal_err", 32'(err), 1);
      chk("illegal_done", 32'(done), 0);
      chk("illegal_busy", 32'(busy), 0);
      chk("illegal_ready", 32'(bus.byte_ready), 0);
      tick();
      chk("illegal_ready2", 32'(bus.byte_ready), 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_err", 32'(err), 1);
    chk("idle_abort_busy", 32'(busy), 0);

    // Abort mid-load, then restart with start and abort on the same edge
    for (int i = 0; i < 4; i++) prog[i] = 16'($urandom);
    start_load(4, 3, 1'b0);
    send_bytes(3, 0, 1'b0);
    abort          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = prog_byte(3);
    tick();
    abort          = 1'b0;
    bus.byte_valid = 1'b0;
    chk("abort_ready", 32'(bus.byte_ready), 0);
    chk("abort_err", 32'(err), 1);
    chk("abort_pr", 32'(bus.pr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    start_load(4, 3, 1'b1);
    send_bytes(8, 0, 1'b0);
    check_run(4, 3);

    // Unbounded run until abort
    prog[0] = 16'h0501;
    start_load(1, 0, 1'b0);
    send_bytes(2, 0, 1'b0);
    check_prime_burst(1);
    for (int c = 0; c < 210; c++) begin
      tick();
      chk("unb_en", 32'(bus.cpu_en), 1);
      chk("unb_pr", 32'(bus.pr), 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("unb_abort_en", 32'(bus.cpu_en), 0);
    chk("unb_abort_err", 32'(err), 1);
    chk("unb_abort_done", 32'(done), 0);
    chk("unb_abort_busy", 32'(busy), 0);

    // Reset during burst of an 11-word program, then a fresh load
    prog[0] = 16'h0501; prog[1] = 16'h0601; prog[2] = 16'h0000;
    prog[3] = 16'h0a01; prog[4] = 16'h3012; prog[5] = 16'h2201;
    prog[6] = 16'h1201; prog[7] = 16'h8a07; prog[8] = 16'h0710;
    prog[9] = 16'h1a02; prog[10] = 16'hf201;
    start_load(11, 4, 1'b0);
    send_bytes(22, 0, 1'b0);
    tick();
    chk("rst_prime_pr", 32'(bus.pr), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_burst_instr", 32'(bus.instr_out), 32'(prog[4'(i)]));
    end
    #2;
    rstz = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rstz = 1'b1;
    tick();
    check_all_zero("postrst");
    set_test1_prog();
    start_load(3, 5, 1'b0);
    send_bytes(6, 0, 1'b0);
    check_run(3, 5);

    // Randomized loads, including full-depth and single-cycle boundaries
    for (int it = 0; it < 6; it++) begin
      len = (it == 0) ? 16 : (it == 1) ? 1 : int'($urandom_range(16, 1));
      rc  = (it == 1) ? 1 : int'($urandom_range(12, 1));
      for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
      start_load(len, rc, 1'b0);
      send_bytes(2 * len, 0, 1'b1);
      check_run(len, rc);
      for (int k = 0; k < int'($urandom_range(3, 0)); k++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mas_prog_sequencer.md
Name: mas_prog_sequencer

Overview:
- Program-load and run sequencer for the 8-bit MAS processor core.
- Accepts a program as a byte stream from a host over a valid/ready handshake and buffers it as 16-bit instruction words.
- Bursts the buffered words into the core in programming mode (pr=1), then switches the core to run mode for a bounded number of cycles and freezes it.
- Sits between the host/test interface and the core's pr/en/instr_in pins.

Parameters:
- IMEM_DEPTH, 16: maximum program length in instructions; must match core instruction memory depth.
- ADDR_W, 4: log2(IMEM_DEPTH).
- RUN_CNT_W, 16: width of the run-cycle budget.

Ports:
- clk  in  1  system clock, rising edge.
- rstz  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy=1.
- prog_len  in  ADDR_W+1  number of instructions to load; sampled on start.
- run_cycles  in  RUN_CNT_W  run-mode cycle budget; sampled on start; 0 = run until abort.
- abort  in  1  cancels any in-progress operation.
- byte_in  in  8  program byte, high byte of each word first.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  sequencer can accept a byte.
- pr  out  1  to core pr: 1 = programming mode.
- cpu_en  out  1  to core en.
- instr_out  out  16  to core instr_in.
- busy  out  1  not in IDLE.
- done  out  1  sticky: last run completed normally.
- err  out  1  sticky: last start rejected or aborted.
- word_cnt  out  ADDR_W+1  words received in the current load.

Behaviour:
- Reset (rstz=0, asynchronous): FSM=IDLE. pr, cpu_en, byte_ready, busy, done and err are 0. instr_out=0, word_cnt=0, byte-phase=high. Buffer contents are don't-care.
- All outputs are registered.
- States: IDLE, RECV, PRIME, BURST, RUN.
- IDLE:
  - Outputs: pr=0, cpu_en=0, byte_ready=0.
  - start with 1<=prog_len<=IMEM_DEPTH: latch prog_len and run_cycles, clear done, err and word_cnt, go to RECV.
  - start with an illegal prog_len (0 or >IMEM_DEPTH): err=1, done=0, stay in IDLE.
- RECV:
  - byte_ready=1.
  - A byte transfers on a clock edge where byte_valid=1 and byte_ready=1.
  - High phase: store the high byte.
  - Low phase: write {hi, byte_in} into buf[word_cnt], then word_cnt+1.
  - The edge that writes word number prog_len moves the FSM to PRIME; byte_ready=0 from the next cycle.
  - Stalls (byte_valid=0) have no effect on state.
- PRIME: exactly 1 cycle with pr=1, cpu_en=1, instr_out=0x0000 (core PC-reset cycle). Then go to BURST with read index 0.
- BURST:
  - pr=1, cpu_en=1, instr_out=buf[idx] for one cycle per word, with consecutive words on consecutive cycles (no gaps).
  - After idx=prog_len-1, go to RUN.
- RUN:
  - pr=0, cpu_en=1, instr_out=0.
  - The run counter starts at 0 and increments each cycle.
  - When the counter reaches run_cycles-1, the next state is IDLE with done=1 and cpu_en=0.
  - Core registers are retained because the core is not reset.
  - run_cycles=0: stay in RUN until abort.
- Timing: with the last byte accepted at edge N, pr and cpu_en rise after edge N+1. The PRIME cycle is followed by prog_len BURST cycles, then exactly run_cycles cycles with cpu_en=1 and pr=0.
- abort:
  - In any non-IDLE state: next state IDLE; pr=0, cpu_en=0, byte_ready=0; err=1, done=0; partial data discarded.
  - abort in IDLE has no effect.
  - abort has priority over byte transfers and state advance on the same edge.
- start while busy is ignored. start and abort on the same edge in IDLE: start wins.
- word_cnt saturates at prog_len and holds until the next accepted start.
- A reset mid-operation returns everything to reset values immediately.

Test Plan:
1. Load and run: prog_len=3, run_cycles=5, bytes 00 03 05 02 15 00 back-to-back -> pr=1 for 4 cycles with instr_out 0000, 0003, 0502, 1500; then 5 cycles with cpu_en=1 and pr=0; then done=1, cpu_en=0, busy=0; core reg1=5.
2. Stalled stream: same program with byte_valid low 3 cycles between each byte -> identical contiguous burst; word_cnt=3 at PRIME.
3. Illegal length: start with prog_len=0, then prog_len=17 (IMEM_DEPTH=16) -> err=1, busy stays 0, byte_ready never asserts.
4. Abort mid-load: prog_len=4, abort after 3 bytes -> next cycle byte_ready=0, err=1, pr=0; a subsequent legal start clears err.
5. Unbounded run: run_cycles=0, 1-word program 0501 -> cpu_en stays 1 for 200+ cycles; abort -> cpu_en=0, err=1, done=0.
6. Reset during BURST of an 11-word program (Fibonacci 0501...f201) -> all outputs 0 asynchronously; after release, a fresh load completes normally.
